// File: rtl/mpaddsub_pipe.sv
// Two-stage carry-select adder/subtractor with a valid/ready handshake.
// S1 computes dual per-segment sums (carry-in 0 and 1). S2 resolves the
// segment carry chain, selects the sums and registers the result.
module mpaddsub_pipe #(
  parameter int unsigned WIDTH = 1027,
  parameter int unsigned SEG   = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             out_zero
);

  localparam int unsigned NSEG = (WIDTH + SEG - 1) / SEG;
  localparam int unsigned TOPW = WIDTH - (NSEG - 1) * SEG;

  logic             en;
  logic [WIDTH-1:0] bp_c;
  logic [WIDTH-1:0] sum_c;
  logic             s1_valid;
  logic             s1_sub;

  // Whole pipe advances together whenever the output slot is free or draining.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Subtraction is a + ~b + 1; the +1 enters as segment-0 carry-in.
  assign bp_c = in_sub ? ~in_b : in_b;

  genvar k;
  for (k = 0; k < NSEG; k++) begin : g_seg
    localparam int unsigned LO = k * SEG;
    localparam int unsigned W  = (k == NSEG - 1) ? TOPW : SEG;

    logic [W:0] suma;
    logic       cout;

    if (k == 0) begin : g_lo
      // Segment 0 needs only one sum; its carry-in is known in S1.
      always_ff @(posedge clk) begin
        if (en) begin
          suma <= {1'b0, in_a[LO +: W]} + {1'b0, bp_c[LO +: W]} + {{W{1'b0}}, in_sub};
        end
      end

      assign sum_c[LO +: W] = suma[W-1:0];
      assign cout           = suma[W];
    end else begin : g_hi
      logic [W:0] sumb;

      // Upper segments precompute both carry-in outcomes.
      always_ff @(posedge clk) begin
        if (en) begin
          suma <= {1'b0, in_a[LO +: W]} + {1'b0, bp_c[LO +: W]};
          sumb <= {1'b0, in_a[LO +: W]} + {1'b0, bp_c[LO +: W]} + {{W{1'b0}}, 1'b1};
        end
      end

      // Carry from the segment below picks which precomputed sum is real.
      assign sum_c[LO +: W] = g_seg[k-1].cout ? sumb[W-1:0] : suma[W-1:0];
      assign cout           = g_seg[k-1].cout ? sumb[W] : suma[W];
    end
  end

  // S1 control: valid bit and operation flag travel with the partial sums.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sub   <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sub   <= in_sub;
    end
  end

  // S2: register the resolved sum; MSB is carry for add, borrow for sub.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_zero  <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      result    <= {s1_sub ^ g_seg[NSEG-1].cout, sum_c};
      out_zero  <= (sum_c == '0);
    end
  end

endmodule

// File: tb/tb_mpaddsub_pipe.sv
// Directed bench for mpaddsub_pipe: three parameterisations share one stimulus.
module tb_mpaddsub_pipe;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sub = 1'b0;
  logic          out_ready = 1'b1;
  logic [1026:0] a = '0;
  logic [1026:0] b = '0;

  logic [1027:0] res0;
  logic [256:0]  res1;
  logic [130:0]  res2;
  logic          ov0, ov1, ov2, z0, z1, z2, ir0, ir1, ir2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mpaddsub_pipe #(.WIDTH(1027), .SEG(128)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0), .in_sub(in_sub),
    .in_a(a), .in_b(b), .out_valid(ov0), .out_ready(out_ready), .result(res0), .out_zero(z0));

  mpaddsub_pipe #(.WIDTH(256), .SEG(64)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .in_sub(in_sub),
    .in_a(a[255:0]), .in_b(b[255:0]), .out_valid(ov1), .out_ready(out_ready),
    .result(res1), .out_zero(z1));

  mpaddsub_pipe #(.WIDTH(130), .SEG(64)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2), .in_sub(in_sub),
    .in_a(a[129:0]), .in_b(b[129:0]), .out_valid(ov2), .out_ready(out_ready),
    .result(res2), .out_zero(z2));

  task automatic chk(input string tag, input logic [1027:0] obs, input logic [1027:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed msb=%b low=%h expected msb=%b low=%h",
             tag, obs[1027], obs[127:0], exp[1027], exp[127:0]);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1026:0] ta, input logic [1026:0] tb, input logic ts);
    a = ta;
    b = tb;
    in_sub = ts;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run1(input string tag, input logic [1026:0] ta, input logic [1026:0] tb,
                      input logic ts, input logic [1027:0] er, input logic ez);
    beat(ta, tb, ts);
    chk({tag, "_lat1"}, 1028'(ov0), 1028'(0));
    tick();
    chk({tag, "_valid"}, 1028'(ov0), 1028'(1));
    chk({tag, "_res"}, res0, er);
    chk({tag, "_zero"}, 1028'(z0), 1028'(ez));
  endtask

  logic [1026:0] ones;
  logic [1026:0] ra[16];
  logic [1026:0] rb[16];
  logic          rs[16];
  logic [1027:0] rexp[16];
  logic [1027:0] e1, e2;

  initial begin
    ones = '1;

    // Reset state
    tick();
    tick();
    chk("rst_ov", 1028'(ov0), 1028'(0));
    chk("rst_res", res0, 1028'(0));
    chk("rst_zero", 1028'(z0), 1028'(0));
    chk("rst_ready", 1028'({ir0, ir1, ir2}), 1028'(3'b111));
    chk("rst_res1", 1028'(res1), 1028'(0));
    chk("rst_res2", 1028'(res2), 1028'(0));
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 1028'(ir0), 1028'(1));
    chk("post_rst_ov", 1028'(ov0), 1028'(0));

    // Directed single beats
    run1("add_full_carry", ones, 1027'(1), 1'b0, {1'b1, 1027'(0)}, 1'b1);
    run1("sub_5_7", 1027'(5), 1027'(7), 1'b1, {1'b1, ones - 1027'(1)}, 1'b0);
    run1("sub_equal", 1027'h1234, 1027'h1234, 1'b1, 1028'(0), 1'b1);
    run1("sub_7_5", 1027'(7), 1027'(5), 1'b1, 1028'(2), 1'b0);
    run1("add_zero", 1027'(0), 1027'(0), 1'b0, 1028'(0), 1'b1);
    run1("sub_0_1", 1027'(0), 1027'(1), 1'b1, {1'b1, ones}, 1'b0);
    run1("add_ones_ones", ones, ones, 1'b0, {1'b1, ones - 1027'(1)}, 1'b0);
    run1("add_small", 1027'h0123_4567, 1027'h0fed_cba9, 1'b0, 1028'h1111_1110, 1'b0);

    // Back-to-back beats against a plain wide-arithmetic reference
    for (int i = 0; i < 16; i++) begin
      ra[i] = '0;
      rb[i] = '0;
      for (int w = 0; w < 33; w++) begin
        ra[i] = {ra[i][994:0], 32'($urandom())};
        rb[i] = {rb[i][994:0], 32'($urandom())};
      end
      rs[i] = 1'($urandom_range(0, 1));
    end
    ra[3] = ones;  rb[3] = 1027'(1); rs[3] = 1'b0;
    ra[5] = 1027'(3); rs[5] = 1'b1;
    ra[9] = rb[9]; rs[9] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rexp[i] = rs[i] ? ({1'b0, ra[i]} - {1'b0, rb[i]}) : ({1'b0, ra[i]} + {1'b0, rb[i]});
    end
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        a = ra[i];
        b = rb[i];
        in_sub = rs[i];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 16) begin
        chk($sformatf("b2b%0d_valid", i - 1), 1028'(ov0), 1028'(1));
        chk($sformatf("b2b%0d_res", i - 1), res0, rexp[i - 1]);
      end
    end
    chk("b2b_drain", 1028'(ov0), 1028'(0));

    // Stall with both stages full
    a = 1027'(100); b = 1027'(23); in_sub = 1'b0; in_valid = 1'b1;
    tick();
    a = 1027'(1000); b = 1027'(1); in_sub = 1'b1;
    tick();
    out_ready = 1'b0;
    a = ones; b = 1027'(0); in_sub = 1'b0;
    #1;
    chk("stall_ready0", 1028'(ir0), 1028'(0));
    chk("stall_res0", res0, 1028'(123));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall%0d_ov", i), 1028'(ov0), 1028'(1));
      chk($sformatf("stall%0d_res", i), res0, 1028'(123));
      chk($sformatf("stall%0d_ready", i), 1028'(ir0), 1028'(0));
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("release_b_ov", 1028'(ov0), 1028'(1));
    chk("release_b_res", res0, 1028'(999));
    tick();
    chk("release_c_ov", 1028'(ov0), 1028'(1));
    chk("release_c_res", res0, {1'b0, ones});
    tick();
    chk("release_drain", 1028'(ov0), 1028'(0));

    // Reset with both stages valid
    a = 1027'(11); b = 1027'(22); in_sub = 1'b0; in_valid = 1'b1;
    tick();
    a = 1027'(33);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("midrst_ov", 1028'(ov0), 1028'(0));
    chk("midrst_res", res0, 1028'(0));
    chk("midrst_zero", 1028'(z0), 1028'(0));
    chk("midrst_ready", 1028'(ir0), 1028'(1));
    reset = 1'b0;
    tick();
    chk("midrst_discard", 1028'(ov0), 1028'(0));
    run1("post_midrst", 1027'h1234, 1027'h0ff0, 1'b0, 1028'h2224, 1'b0);

    // Segment-boundary carries, 64-bit segments (u1, u2) and u0
    for (int k = 1; k <= 4; k++) begin
      beat((1027'(1) << (64 * k)) - 1027'(1), 1027'(1), 1'b0);
      tick();
      e1 = 1028'(1) << (64 * k);
      e2 = (64 * k >= 130) ? (1028'(1) << 130) : e1;
      chk($sformatf("seg64_k%0d_u1_ov", k), 1028'(ov1), 1028'(1));
      chk($sformatf("seg64_k%0d_u1_res", k), 1028'(res1), e1);
      chk($sformatf("seg64_k%0d_u1_zero", k), 1028'(z1), 1028'(k == 4));
      chk($sformatf("seg64_k%0d_u2_res", k), 1028'(res2), e2);
      chk($sformatf("seg64_k%0d_u2_zero", k), 1028'(z2), 1028'(64 * k >= 130));
      chk($sformatf("seg64_k%0d_u0_res", k), res0, e1);
    end
    for (int k = 1; k <= 8; k++) begin
      beat((1027'(1) << (128 * k)) - 1027'(1), 1027'(1), 1'b0);
      tick();
      chk($sformatf("seg128_k%0d_res", k), res0, 1028'(1) << (128 * k));
      chk($sformatf("seg128_k%0d_zero", k), 1028'(z0), 1028'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mpaddsub_pipe.md
MPADDSUB_PIPE -- requirements
Module: mpaddsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 1027, operand width in bits (WIDTH > SEG).
REQ-002 SHALL have parameter SEG, default 128, carry-select segment width; NSEG = ceil(WIDTH/SEG); top segment width = WIDTH-(NSEG-1)*SEG.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port in_sub  input  1  0 = a+b, 1 = a-b; sampled with operands.
REQ-008 SHALL have port in_a  input  WIDTH  unsigned operand A.
REQ-009 SHALL have port in_b  input  WIDTH  unsigned operand B.
REQ-010 SHALL have port out_valid  output  1  result beat valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port result  output  WIDTH+1  sum/difference; MSB = carry (add) or borrow (sub).
REQ-013 SHALL have port out_zero  output  1  result[WIDTH-1:0] == 0.

Function
REQ-014 SHALL transfer an input beat only when in_valid && in_ready, and an output beat only when out_valid && out_ready.
REQ-015 SHALL define advance enable en = !out_valid || out_ready; in_ready SHALL equal en (combinational, no dependence on in_valid).
REQ-016 SHALL implement a 2-stage pipeline (S1, S2), each with a valid bit; both stages load only when en = 1, and hold all contents when en = 0.
REQ-017 S1 SHALL register, per segment k, suma_k = a_k + b'_k and sumb_k = a_k + b'_k + 1 with their carries, where b' = in_b when in_sub = 0, ~in_b when in_sub = 1.
REQ-018 S1 SHALL register segment 0 sum with carry-in = in_sub (no dual sum needed), plus in_sub and S1 valid = in_valid.
REQ-019 S2 SHALL resolve the carry chain c_0 = segment-0 carry, c_k = c_(k-1) ? carryb_k : carrya_k, select sumb_k when c_(k-1) = 1 else suma_k, and register the WIDTH-bit sum.
REQ-020 S2 SHALL register result[WIDTH] = c_final when sub = 0 and ~c_final when sub = 1 (1 means a < b).
REQ-021 For sub, result[WIDTH-1:0] SHALL equal (a - b) mod 2^WIDTH.
REQ-022 out_zero SHALL be registered in S2 from the selected WIDTH-bit sum, independent of MSB.
REQ-023 out_valid SHALL equal S2 valid; result and out_zero SHALL be the S2 registers.
REQ-024 Latency SHALL be exactly 2 cycles from accepted input to out_valid when out_ready is held 1.
REQ-025 Throughput SHALL be 1 beat/cycle while out_ready = 1; no bubble inserted on a stall release.
REQ-026 When out_valid = 1 and out_ready = 0, result, out_zero and out_valid SHALL be stable and in_ready SHALL be 0.
REQ-027 Beats SHALL never be dropped, duplicated or reordered; S1 bubbles (valid 0) SHALL propagate as out_valid = 0.
REQ-028 Parameters with WIDTH a multiple of SEG (top segment full width) SHALL be supported identically.

Reset
REQ-029 When reset = 1 at a rising edge, S1 valid, S2 valid, out_valid SHALL become 0; result and out_zero SHALL become 0.
REQ-030 Reset SHALL override en and any handshake; beats in flight at reset SHALL be discarded.
REQ-031 During reset and the cycle after, in_ready SHALL read 1 (out_valid = 0).

Verification
REQ-032 Add, WIDTH=1027: a = 2^1027-1, b = 1, out_ready = 1 -> after 2 cycles result = 2^1027 (MSB 1, rest 0), out_zero = 1; full carry ripples through all 9 segments.
REQ-033 Sub: a = 5, b = 7 -> result[1026:0] = 2^1027-2, result[1027] = 1, out_zero = 0; a = b = 0x1234 -> result = 0, out_zero = 1.
REQ-034 Back-to-back 16 random add/sub beats with out_ready = 1 -> 16 consecutive out_valid cycles, results match reference model in order.
REQ-035 Stall: out_ready = 0 for 5 cycles with pipeline full -> in_ready = 0, result held stable; on release both beats emerge on consecutive cycles.
REQ-036 Reset asserted with both stages valid -> next cycle out_valid = 0, result = 0; subsequent beat returns correct result after 2 cycles.
REQ-037 Parameter sweep (WIDTH,SEG) = (256,64), (130,64), (1027,128) -> segment-boundary carries (a = 2^(k*SEG)-1, b = 1) correct for each k.
